// File: rtl/carry_resolve_seq.sv
// Sequential carry-save to non-redundant resolver: folds (C,S) digit pairs into
// DIGIT_W-bit digits DPC at a time, rippling a small carry between chunks.
module carry_resolve_seq #(
    parameter int unsigned NUM_DIGITS = 130,
    parameter int unsigned IN_W       = 19,
    parameter int unsigned DIGIT_W    = 16,
    parameter int unsigned DPC        = 26,
    parameter int unsigned CARRY_W    = 5
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_DIGITS-1:0][IN_W-1:0]      C,
    input  logic [NUM_DIGITS-1:0][IN_W-1:0]      S,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   Z,
    output logic [CARRY_W-1:0]                   carry_out
);

    localparam int unsigned NCH   = NUM_DIGITS / DPC;
    localparam int unsigned CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned SUM_W = IN_W + 2;

    generate
        if ((NUM_DIGITS % DPC) != 0) begin : g_bad_dpc
            $error("carry_resolve_seq: NUM_DIGITS must be a multiple of DPC");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [CARRY_W-1:0]                   carry_q, carry_d;
    logic [NUM_DIGITS-1:0][IN_W-1:0]      c_q, c_d;
    logic [NUM_DIGITS-1:0][IN_W-1:0]      s_q, s_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   z_q, z_d;
    logic [CARRY_W-1:0]                   cout_q, cout_d;
    logic                                 out_valid_q, out_valid_d;

    logic [IDX_W-1:0]                     base;
    logic [IDX_W-1:0]                     idx;
    logic [SUM_W-1:0]                     rip_t;
    logic [CARRY_W-1:0]                   rip_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= '0;
            c_q         <= '0;
            s_q         <= '0;
            z_q         <= '0;
            cout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            c_q         <= c_d;
            s_q         <= s_d;
            z_q         <= z_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic and one-chunk ripple resolution
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_d     = c_q;
        s_d     = s_q;
        z_d     = z_q;
        cout_d  = cout_q;
        base    = IDX_W'(cnt_q) * IDX_W'(DPC);
        idx     = '0;
        rip_t   = '0;
        rip_c   = carry_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    c_d     = C;
                    s_d     = S;
                    cnt_d   = '0;
                    carry_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int j = 0; j < int'(DPC); j++) begin
                    idx      = base + IDX_W'(j);
                    rip_t    = SUM_W'(c_q[idx]) + SUM_W'(s_q[idx]) + SUM_W'(rip_c);
                    z_d[idx] = rip_t[DIGIT_W-1:0];
                    rip_c    = CARRY_W'(rip_t >> DIGIT_W);
                end
                carry_d = rip_c;
                if (cnt_q == CNT_W'(NCH - 1)) begin
                    cout_d  = rip_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign Z         = z_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_carry_resolve_seq.sv
// Directed bench for carry_resolve_seq: table of hand-computed operands plus
// backpressure and mid-run reset sequences.
module tb_carry_resolve_seq;

    localparam int unsigned ND  = 130;
    localparam int unsigned IW  = 19;
    localparam int unsigned DW  = 16;
    localparam int unsigned DPC = 26;
    localparam int unsigned CW  = 5;
    localparam int          LAT = 5;

    typedef logic [ND-1:0][IW-1:0] cs_t;
    typedef logic [ND-1:0][DW-1:0] z_t;

    typedef struct {
        string          name;
        cs_t            c;
        cs_t            s;
        z_t             exp_z;
        logic [CW-1:0]  exp_cout;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    cs_t           C;
    cs_t           S;
    logic          out_valid;
    logic          out_ready;
    z_t            Z;
    logic [CW-1:0] carry_out;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [4];

    carry_resolve_seq #(
        .NUM_DIGITS(ND), .IN_W(IW), .DIGIT_W(DW), .DPC(DPC), .CARRY_W(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .C         (C),
        .S         (S),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Z         (Z),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_z(input string nm, input z_t exp);
        int first;
        n_checks++;
        if (Z !== exp) begin
            n_fail++;
            first = -1;
            for (int d = 0; d < int'(ND); d++)
                if (first < 0 && Z[d] !== exp[d]) first = d;
            $display("FAIL %s: Z[%0d] got 0x%0h expected 0x%0h", nm, first, Z[first], exp[first]);
        end
    endtask

    task automatic scramble();
        for (int d = 0; d < int'(ND); d++) begin
            C[d] = IW'($urandom);
            S[d] = IW'($urandom);
        end
    endtask

    // Accept v at the next edge, time out_valid, check result; optionally drain.
    task automatic run_op(input vec_t v, input bit drain);
        int  n;
        bit  rdy_seen;
        C        = v.c;
        S        = v.s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        n        = 0;
        rdy_seen = 1'b0;
        while (n < 20) begin
            if (in_ready) rdy_seen = 1'b1;
            if (out_valid) break;
            @(posedge clk); #1;
            n++;
        end
        chk({v.name, " latency"}, 64'(n), 64'(LAT));
        chk({v.name, " in_ready low while busy"}, 64'(rdy_seen), 64'd0);
        chk_z({v.name, " Z"}, v.exp_z);
        chk({v.name, " carry_out"}, 64'(carry_out), 64'(v.exp_cout));
        if (drain) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk({v.name, " out_valid after drain"}, 64'(out_valid), 64'd0);
            chk({v.name, " in_ready after drain"}, 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        z_t  hold_z;
        logic [CW-1:0] hold_c;

        // Vector table with hand-computed expectations
        vecs[0].name = "zero";
        vecs[0].c = '0; vecs[0].s = '0; vecs[0].exp_z = '0; vecs[0].exp_cout = '0;

        vecs[1].name = "digit0_carry";
        vecs[1].c = '0; vecs[1].s = '0; vecs[1].exp_z = '0; vecs[1].exp_cout = '0;
        vecs[1].c[0] = 19'h0FFFF; vecs[1].s[0] = 19'h00001;
        vecs[1].exp_z[1] = 16'h0001;

        vecs[2].name = "chunk_ripple";
        vecs[2].c = '0; vecs[2].s = '0; vecs[2].exp_z = '0; vecs[2].exp_cout = '0;
        for (int d = 0; d < 26; d++) vecs[2].c[d] = 19'h0FFFF;
        vecs[2].s[0] = 19'h00001;
        vecs[2].exp_z[26] = 16'h0001;

        vecs[3].name = "all_max";
        vecs[3].c = '1; vecs[3].s = '1;
        for (int d = 0; d < int'(ND); d++) vecs[3].exp_z[d] = 16'h000E;
        vecs[3].exp_z[0] = 16'hFFFE;
        vecs[3].exp_z[1] = 16'h000D;
        vecs[3].exp_cout = 5'h10;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; C = '0; S = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk_z("reset Z", '0);
        chk("reset carry_out", 64'(carry_out), 64'd0);

        for (int i = 0; i < 4; i++) run_op(vecs[i], 1'b1);

        // Backpressure: hold result under churning inputs
        run_op(vecs[3], 1'b0);
        hold_z = Z;
        hold_c = carry_out;
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            scramble();
            @(posedge clk); #1;
            chk("bp out_valid", 64'(out_valid), 64'd1);
            chk("bp in_ready", 64'(in_ready), 64'd0);
            chk_z("bp Z stable", hold_z);
            chk("bp carry_out stable", 64'(carry_out), 64'(hold_c));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release out_valid", 64'(out_valid), 64'd0);
        chk("bp release in_ready", 64'(in_ready), 64'd1);
        chk_z("bp Z kept after release", vecs[3].exp_z);
        run_op(vecs[2], 1'b1);

        // Reset at the second edge after accept
        C = vecs[3].c; S = vecs[3].s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        chk_z("midrst Z", '0);
        chk("midrst carry_out", 64'(carry_out), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("midrst no out_valid pulse", 64'(out_valid), 64'd0);
        end
        run_op(vecs[1], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
